// File: rtl/ooo_fetch_queue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ooo_fetch_queue_stage_pkg
// Purpose  : Shared types for the out-of-order fetch stage. Provides the
//            machine word type, the queued fetch entry, the fetch state
//            encoding, the bus endianness selection and a byte-swap helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ooo_fetch_queue_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        BIG_ENDIAN    = 1'b0,
        LITTLE_ENDIAN = 1'b1
    } endian_t;

    // Byte order of the instruction bus as delivered by the memory system.
    localparam endian_t BUS_ENDIANNESS = LITTLE_ENDIAN;

    // One decoded-side queue slot: the instruction word plus the metadata
    // decode needs without recomputing it.
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  pred;
        logic  mal;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ooo_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ooo_fetch_queue
// Purpose  : Parametrised circular FIFO of fetch_entry_t with push, pop and
//            single-cycle flush. The head entry is presented from registers;
//            it reads as all-zero when the queue is empty.
// Ports    : CLK, nRST        clock, asynchronous active-low reset
//            push, push_data  enqueue request (ignored when full)
//            pop              dequeue request (ignored when empty)
//            flush            empty the queue (wins over push and pop)
//            head, head_valid current head entry and its valid flag
//            count            number of occupied entries
// Revision : 1.0  initial release
// ============================================================================
module ooo_fetch_queue
    import ooo_fetch_queue_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one        = (AW+1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push & (count_q != c_full_count) & ~flush;
    assign do_pop  = pop  & (count_q != '0)           & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Drop everything by catching the read pointer up to the write
            // pointer; storage contents are simply abandoned.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + c_one;
                2'b01:   count_d = count_q - c_one;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only ever read after being written.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_valid = (count_q != '0);
    assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/ooo_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : ooo_fetch_queue_stage
// Purpose  : Decoupled instruction fetch. Generates the fetch PC, issues
//            generic-bus reads, tags each instruction with its prediction
//            and buffers it in an N-entry queue read by decode through a
//            valid/ready handshake. Redirects that arrive while a read is
//            outstanding keep the request stable and discard its data.
// Ports    : CLK, nRST                  clock, asynchronous active-low reset
//            halt, redirect, redirect_pc control from hazard logic
//            bus_*                      generic instruction bus master
//            pred_pc/pred_taken/target  branch predictor lookup
//            out_*                      queue head to decode
//            i_mem_busy                 bus busy echoed to hazard unit
// Revision : 1.0  initial release
// ============================================================================
module ooo_fetch_queue_stage
    import ooo_fetch_queue_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [3:0]  bus_byte_en,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        out_pred,
    output logic        out_mal,
    output logic        i_mem_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;

    word_t        instr_w;
    word_t        pc4_w;
    logic         aligned;
    logic         has_space;
    logic         ren;
    logic         complete;
    logic         outstanding;

    logic         q_push;
    fetch_entry_t q_push_data;
    logic         q_pop;
    logic         q_flush;
    fetch_entry_t q_head;
    logic         q_head_valid;
    logic [AW:0]  q_count;

    generate
        if (BUS_ENDIANNESS == LITTLE_ENDIAN) begin : g_little_endian
            assign instr_w = byte_swap(bus_rdata);
        end else begin : g_big_endian
            assign instr_w = bus_rdata;
        end
    endgenerate

    assign pc4_w     = pc_q + 32'd4;
    assign aligned   = (pc_q[1:0] == 2'b00);
    // Uses the registered count: a pop this cycle does not free a slot
    // for the request until the next cycle.
    assign has_space = (q_count != c_full_count);

    // Request generation. Gated by nRST so the bus sees no read while the
    // stage is held in reset.
    always_comb begin
        ren = 1'b0;
        case (state_q)
            RUN:     ren = aligned & has_space;
            DRAIN:   ren = 1'b1;
            default: ren = 1'b0;
        endcase
        ren = ren & ~halt & nRST;
    end

    assign complete    = ren & ~bus_busy;
    assign outstanding = ren &  bus_busy;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        q_push      = 1'b0;
        q_push_data = '0;
        q_flush     = 1'b0;

        if (halt) begin
            q_flush = 1'b1;
            pc_d    = RESET_PC;
            state_d = RUN;
        end else if (redirect) begin
            q_flush = 1'b1;
            if (outstanding) begin
                // The bus must see a stable request, so park the target
                // and keep presenting the old address until it completes.
                pend_pc_d = redirect_pc;
                state_d   = DRAIN;
            end else begin
                pc_d    = redirect_pc;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (aligned) begin
                        if (complete) begin
                            q_push      = 1'b1;
                            q_push_data = '{instr: instr_w, pc: pc_q, pc4: pc4_w,
                                            pred: pred_taken, mal: 1'b0};
                            pc_d        = pred_taken ? pred_target : pc4_w;
                        end
                    end else if (has_space) begin
                        q_push      = 1'b1;
                        q_push_data = '{instr: 32'd0, pc: pc_q, pc4: pc4_w,
                                        pred: 1'b0, mal: 1'b1};
                        state_d     = FAULT;
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        pc_d    = pend_pc_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    // FAULT waits for a redirect with the PC frozen.
                end
            endcase
        end
    end

    assign q_pop = q_head_valid & out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    ooo_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK        (CLK),
        .nRST       (nRST),
        .push       (q_push),
        .push_data  (q_push_data),
        .pop        (q_pop),
        .flush      (q_flush),
        .head       (q_head),
        .head_valid (q_head_valid),
        .count      (q_count)
    );

    assign bus_addr    = pc_q;
    assign bus_ren     = ren;
    assign bus_wen     = 1'b0;
    assign bus_byte_en = 4'b1111;
    assign bus_wdata   = 32'd0;
    assign pred_pc     = pc_q;
    assign i_mem_busy  = bus_busy;

    assign out_valid   = q_head_valid;
    assign out_instr   = q_head.instr;
    assign out_pc      = q_head.pc;
    assign out_pc4     = q_head.pc4;
    assign out_pred    = q_head.pred;
    assign out_mal     = q_head.mal;

endmodule
`default_nettype wire

// File: tb/tb_ooo_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooo_fetch_queue_stage
// Purpose  : Self-checking bench for ooo_fetch_queue_stage. Drives random
//            bus, predictor, redirect, halt and decode-ready traffic and
//            compares every output each cycle against a queue-based
//            reference model of the fetch behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_ooo_fetch_queue_stage;
    import ooo_fetch_queue_stage_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          N_CYCLES = 4000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic        bus_wen;
    logic [3:0]  bus_byte_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_pred;
    logic        out_mal;
    logic        i_mem_busy;

    always #5 CLK = ~CLK;

    ooo_fetch_queue_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus_addr    (bus_addr),
        .bus_ren     (bus_ren),
        .bus_wen     (bus_wen),
        .bus_byte_en (bus_byte_en),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_busy    (bus_busy),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .out_pred    (out_pred),
        .out_mal     (out_mal),
        .i_mem_busy  (i_mem_busy)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pred;
        logic        mal;
    } exp_entry_t;

    exp_entry_t  m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_draining;
    bit          m_faulted;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %08h expected %08h at t=%0t",
                      tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] ref_instr(input logic [31:0] w);
        logic [31:0] r;
        if (BUS_ENDIANNESS == LITTLE_ENDIAN) begin
            for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic bit model_ren();
        if (!nRST || halt || m_faulted) return 1'b0;
        if (m_draining) return 1'b1;
        return (m_pc[1:0] == 2'b00) && (m_q.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        bit exp_v;
        exp_v = (m_q.size() > 0);
        check_eq("bus_ren",     {31'd0, bus_ren},    {31'd0, model_ren()});
        check_eq("bus_addr",    bus_addr,            m_pc);
        check_eq("pred_pc",     pred_pc,             m_pc);
        check_eq("bus_wen",     {31'd0, bus_wen},    32'd0);
        check_eq("bus_byte_en", {28'd0, bus_byte_en}, 32'h0000_000F);
        check_eq("bus_wdata",   bus_wdata,           32'd0);
        check_eq("i_mem_busy",  {31'd0, i_mem_busy}, {31'd0, bus_busy});
        check_eq("out_valid",   {31'd0, out_valid},  {31'd0, exp_v});
        check_eq("out_instr",   out_instr, exp_v ? m_q[0].instr : 32'd0);
        check_eq("out_pc",      out_pc,    exp_v ? m_q[0].pc    : 32'd0);
        check_eq("out_pc4",     out_pc4,   exp_v ? m_q[0].pc4   : 32'd0);
        check_eq("out_pred",    {31'd0, out_pred},
                 {31'd0, exp_v ? m_q[0].pred : 1'b0});
        check_eq("out_mal",     {31'd0, out_mal},
                 {31'd0, exp_v ? m_q[0].mal : 1'b0});
    endtask

    // Advance the model across one rising edge using the inputs that were
    // applied during the cycle that just ended.
    task automatic update_model();
        bit         ren;
        bit         done;
        int         size_before;
        exp_entry_t e;
        ren         = model_ren();
        done        = ren && !bus_busy;
        size_before = m_q.size();
        if (halt) begin
            m_q.delete();
            m_pc       = RESET_PC;
            m_draining = 1'b0;
            m_faulted  = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            if (ren && bus_busy) begin
                m_pend     = redirect_pc;
                m_draining = 1'b1;
            end else begin
                m_pc       = redirect_pc;
                m_draining = 1'b0;
                m_faulted  = 1'b0;
            end
        end else begin
            if (size_before > 0 && out_ready) void'(m_q.pop_front());
            if (m_draining) begin
                if (done) begin
                    m_pc       = m_pend;
                    m_draining = 1'b0;
                end
            end else if (!m_faulted) begin
                if (m_pc[1:0] == 2'b00) begin
                    if (done) begin
                        e.instr = ref_instr(bus_rdata);
                        e.pc    = m_pc;
                        e.pc4   = m_pc + 32'd4;
                        e.pred  = pred_taken;
                        e.mal   = 1'b0;
                        m_q.push_back(e);
                        m_pc = pred_taken ? pred_target : m_pc + 32'd4;
                    end
                end else if (size_before < DEPTH) begin
                    e.instr = 32'd0;
                    e.pc    = m_pc;
                    e.pc4   = m_pc + 32'd4;
                    e.pred  = 1'b0;
                    e.mal   = 1'b1;
                    m_q.push_back(e);
                    m_faulted = 1'b1;
                end
            end
        end
    endtask

    task automatic randomize_inputs(input int cyc);
        int ready_pct;
        int sel;
        case ((cyc / 150) % 3)
            0:       ready_pct = 90;
            1:       ready_pct = 15;
            default: ready_pct = 60;
        endcase
        out_ready  = ($urandom_range(0, 99) < ready_pct);
        halt       = ($urandom_range(0, 99) < 2);
        redirect   = ($urandom_range(0, 99) < 5);
        bus_busy   = ($urandom_range(0, 99) < 30);
        bus_rdata  = $urandom;
        pred_taken = ($urandom_range(0, 99) < 10);
        pred_target = RESET_PC + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 99) < 5) pred_target = pred_target + 32'd2;
        sel = $urandom_range(0, 19);
        if (sel == 0)
            redirect_pc = 32'hFFFF_FFFC;
        else if (sel < 3)
            redirect_pc = RESET_PC + ($urandom_range(0, 255) << 2)
                          + $urandom_range(1, 3);
        else
            redirect_pc = RESET_PC + ($urandom_range(0, 255) << 2);
    endtask

    initial begin
        nRST        = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        bus_rdata   = 32'd0;
        bus_busy    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = 32'd0;
        out_ready   = 1'b0;
        m_pc        = RESET_PC;
        m_pend      = RESET_PC;
        m_draining  = 1'b0;
        m_faulted   = 1'b0;

        repeat (3) begin
            @(negedge CLK);
            #1 check_outputs();
        end

        @(negedge CLK);
        nRST = 1'b1;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            randomize_inputs(cyc);
            #1 check_outputs();
            @(posedge CLK);
            update_model();
            @(negedge CLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ooo_fetch_queue_stage.md
# ooo_fetch_queue_stage

Decoupled instruction fetch for the out-of-order pipeline: PC generation, generic-bus instruction reads, and an N-entry instruction queue feeding decode through a valid/ready handshake. It sits between the instruction generic bus / branch predictor and the decode stage. It generalises the single-latch fetch stage with parametrised queue depth and per-entry prediction tagging. It also discards in-flight responses on redirect, so the bus request stays stable.

## Interface
- RESET_PC, 32'h80000000, PC after reset and after halt
- DEPTH, 4, queue entries; power of two, ≥2
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- halt  in  1  synchronous halt: clears queue, PC←RESET_PC, no bus request
- redirect  in  1  flush and refetch (branch mispredict, priv, fence, CSR); resolved by hazard logic
- redirect_pc  in  32  new fetch PC
- bus_addr  out  32  generic bus address (= fetch PC)
- bus_ren  out  1  read request
- bus_wen  out  1  tied 0
- bus_byte_en  out  4  tied 4'b1111
- bus_wdata  out  32  tied 0
- bus_rdata  in  32  read data, valid when ren & ~busy
- bus_busy  in  1  request not yet complete
- pred_pc  out  32  = fetch PC
- pred_taken  in  1  predictor says taken for pred_pc
- pred_target  in  32  predicted target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  instruction, endian-corrected
- out_pc, out_pc4  out  32  head PC and PC+4
- out_pred  out  1  prediction taken when fetched
- out_mal  out  1  misaligned fetch
- i_mem_busy  out  1  = bus_busy, to hazard unit

## Operation
- States: RUN, DRAIN, FAULT. Reset/halt → RUN.
- RUN, pc[1:0]==0: bus_ren = ~halt & (count<DEPTH). Completion = bus_ren & ~bus_busy: push {instr, pc, pc+4, pred_taken, mal=0}. PC ← pred_taken ? pred_target : pc+4.
- RUN, pc[1:0]≠0: no bus request. If count<DEPTH, push {instr=0, pc, pc+4, pred=0, mal=1} → FAULT.
- FAULT: no requests, hold PC until redirect.
- redirect in any state: queue emptied (count←0, rd_ptr←wr_ptr), no push that cycle.
  - If a bus request is outstanding (bus_ren & bus_busy): latch redirect_pc into pend_pc → DRAIN. bus_addr and bus_ren held.
  - Otherwise PC ← redirect_pc → RUN.
- DRAIN: hold addr and ren. On completion, discard data, PC ← pend_pc → RUN. A further redirect in DRAIN overwrites pend_pc. A redirect in the completion cycle has its target used.
- Pop on out_valid & out_ready. Push and pop in the same cycle leaves count unchanged. A full queue with a pop still blocks ren that cycle (ren uses registered count).
- Pointers: log2(DEPTH)-bit, wrap naturally. count is log2(DEPTH)+1 bits. PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 = 0.
- Priority: nRST > halt > redirect > completion/push > pop.
- Endianness: little → byte-swap bus_rdata; big → pass through.

## Timing
- Reset values: PC=RESET_PC, state=RUN, count=0, out_valid=0. out_instr/pc/pc4/pred/mal = 0 when empty. bus_ren=0 during reset; it is 1 in the first cycle after reset.
- Zero-wait bus: completion in cycle N, out_valid in N+1. Throughput is 1 instr/cycle.
- Decode-side outputs come from registers only (queue head). No combinational path from bus_rdata to out_*.
- A redirect at edge N: first new request issued in cycle N+1 (no outstanding request) or the cycle after drain completion.
- halt wins over an outstanding request; the bus is expected to tolerate ren dropping under halt.

## Structure
- Package rv32i_types_pkg: word_t. Add to ooo shared package: fetch_entry_t {instr, pc, pc4, pred, mal} and fetch_state_t {RUN, DRAIN, FAULT}. BUS_ENDIANNESS stays from component_selection_defines.
- Sub-module ooo_fetch_queue: parametrised circular FIFO of fetch_entry_t with push/pop/flush/count. Reusable elsewhere.
- endian_swapper instantiated for little-endian.

## Test plan
- Reset, zero-wait bus, out_ready=1, no prediction → addrs 80000000, 80000004, …. out_pc follows one cycle after each completion, 1/cycle.
- out_ready=0, DEPTH=4 → exactly 4 completions, then bus_ren=0. Release ready → ren returns in the cycle after the first pop, order preserved.
- pred_taken=1, target 80000100 at pc 80000008 → next addr 80000100. Entry 80000008 has out_pred=1, others 0.
- busy held 3 cycles on 80000010, redirect to 80000200 in cycle 1 → addr stays 80000010 until completion. Data dropped, queue empty, next addr 80000200, no entry for 80000010.
- redirect_pc=80000202 → one entry with out_mal=1 and no bus request. ren stays 0 until redirect to 80000300.
- halt mid-stream with 3 queued → out_valid=0 next cycle. After halt drops, fetch restarts at 80000000.
